cam_capture_ctrl: RTL and testbench

Frame-capture sequencer for the OV7670 camera path, running entirely in the system clock domain.
- Oversamples the camera's raw `pclk`/`href`/`vsync`/data through synchronisers.
- Arms on a software start command and waits for a clean frame boundary.
- Drives the image RAM write port (enable, address, data) for exactly one frame, then reports the byte count and completion.
- Sits between the Wishbone camera register block (start/abort/status) and the image RAM.

---
 rtl/cam_capture_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - OV7670 single-frame capture sequencer driving the image RAM write port
//
// The camera's pclk/href/vsync/data are oversampled in the clk domain. A capture is
// armed by a start pulse and runs from the next VSYNC fall to the following VSYNC rise.
// Optional build macro: CAM_BYTE_PACK_EN packs byte pairs into 16-bit words
// (word addresses, limit MAX_BYTES/2 words). Without it, one write is made per byte.

module cam_capture_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int MAX_BYTES   = 153600,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_pclk,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] MAX_BYTES_C = CNT_W'(MAX_BYTES);
`ifdef CAM_BYTE_PACK_EN
  localparam logic [CNT_W-1:0] WR_LIMIT_C  = CNT_W'(MAX_BYTES / 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  // Synchroniser chains; data travels with the same depth as pclk so a
  // detected pclk rise always sees the byte the camera presented with it.
  logic [SYNC_STAGES-1:0] pclk_sync_q;
  logic [SYNC_STAGES-1:0] href_sync_q;
  logic [SYNC_STAGES-1:0] vs_sync_q;
  logic [7:0]             data_sync_q [SYNC_STAGES];
  logic                   pclk_prev_q;
  logic                   vs_prev_q;

  logic       pclk_s;
  logic       href_s;
  logic       vs_s;
  logic [7:0] data_s;
  logic       pclk_rise;
  logic       vs_fall;
  logic       vs_rise;
  logic       byte_valid;

  state_t            state_q,      state_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;
  logic              overflow_q,   overflow_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              wr_en_q,      wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [15:0]       wr_data_q,    wr_data_d;
  logic              done_q,       done_d;
`ifdef CAM_BYTE_PACK_EN
  logic              pair_q,       pair_d;
  logic [7:0]        hi_byte_q,    hi_byte_d;
`endif

  // Oversample the raw camera signals and keep one previous sample for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sync_q <= '0;
      href_sync_q <= '0;
      vs_sync_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= 8'h00;
      end
      pclk_prev_q <= 1'b0;
      vs_prev_q   <= 1'b0;
    end else begin
      pclk_sync_q[0] <= cam_pclk;
      href_sync_q[0] <= cam_href;
      vs_sync_q[0]   <= cam_vsync;
      data_sync_q[0] <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pclk_sync_q[i] <= pclk_sync_q[i-1];
        href_sync_q[i] <= href_sync_q[i-1];
        vs_sync_q[i]   <= vs_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
      pclk_prev_q <= pclk_sync_q[SYNC_STAGES-1];
      vs_prev_q   <= vs_sync_q[SYNC_STAGES-1];
    end
  end

  // Synchronised levels and single-cycle edge strobes.
  always_comb begin
    pclk_s     = pclk_sync_q[SYNC_STAGES-1];
    href_s     = href_sync_q[SYNC_STAGES-1];
    vs_s       = vs_sync_q[SYNC_STAGES-1];
    data_s     = data_sync_q[SYNC_STAGES-1];
    pclk_rise  = pclk_s & ~pclk_prev_q;
    vs_fall    = ~vs_s & vs_prev_q;
    vs_rise    = vs_s & ~vs_prev_q;
    byte_valid = pclk_rise & href_s;
  end

  // Capture state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 16'h0000;
      done_q       <= 1'b0;
`ifdef CAM_BYTE_PACK_EN
      pair_q       <= 1'b0;
      hi_byte_q    <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
`ifdef CAM_BYTE_PACK_EN
      pair_q       <= pair_d;
      hi_byte_q    <= hi_byte_d;
`endif
    end
  end

  // Next state, byte accounting and the registered RAM write request.
  // Abort has priority over everything, including a start in the same cycle,
  // and suppresses the write that would otherwise be issued next cycle.
  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    overflow_d   = overflow_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
`ifdef CAM_BYTE_PACK_EN
    pair_d       = pair_q;
    hi_byte_d    = hi_byte_q;
`endif

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d      = S_ARMED;
            byte_count_d = '0;
            overflow_d   = 1'b0;
            addr_d       = '0;
`ifdef CAM_BYTE_PACK_EN
            pair_d       = 1'b0;
`endif
          end
        end

        S_ARMED: begin
          // Only a falling VSYNC marks a clean frame start; a rise is ignored.
          if (vs_fall) begin
            state_d = S_CAPTURE;
`ifdef CAM_BYTE_PACK_EN
            pair_d  = 1'b0;
`endif
          end
        end

        S_CAPTURE: begin
          if (byte_valid) begin
            if (byte_count_q != CNT_MAX) begin
              byte_count_d = byte_count_q + CNT_W'(1);
            end
            if (byte_count_q >= MAX_BYTES_C) begin
              overflow_d = 1'b1;
            end
`ifdef CAM_BYTE_PACK_EN
            pair_d = ~pair_q;
            if (!pair_q) begin
              hi_byte_d = data_s;
            end else if ({1'b0, addr_q} < WR_LIMIT_C) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {hi_byte_q, data_s};
              addr_d    = addr_q + ADDR_W'(1);
            end
`else
            if (byte_count_q < MAX_BYTES_C) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {8'h00, data_s};
              addr_d    = addr_q + ADDR_W'(1);
            end
`endif
          end
          // A byte arriving with the closing VSYNC edge is still written above.
          if (vs_rise) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output drive straight from registers.
  always_comb begin
    wr_en      = wr_en_q;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
    busy       = (state_q != S_IDLE);
    done       = done_q;
    overflow   = overflow_q;
    byte_count = byte_count_q;
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - directed self-checking bench for cam_capture_ctrl

module tb_cam_capture_ctrl;

  localparam int ADDR_W  = 18;
  localparam int SMALL_MAX = 20;
`ifdef CAM_BYTE_PACK_EN
  localparam int FULL_W  = 16;
  localparam int SMALL_W = 10;
  localparam int ABORT_W = 5;
`else
  localparam int FULL_W  = 32;
  localparam int SMALL_W = 20;
  localparam int ABORT_W = 10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              cam_vsync;
  logic              cam_href;
  logic              cam_pclk;
  logic [7:0]        cam_data;

  logic              wr_en,      o_wr_en;
  logic [ADDR_W-1:0] wr_addr,    o_wr_addr;
  logic [15:0]       wr_data,    o_wr_data;
  logic              busy,       o_busy;
  logic              done,       o_done;
  logic              overflow,   o_overflow;
  logic [ADDR_W:0]   byte_count, o_byte_count;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0, o_wr_cnt = 0, done_cnt = 0, o_done_cnt = 0;
  int w0, ow0, d0, od0;
  bit exp_cap = 1'b0;
  int exp_idx = 0;
  logic [7:0] prev_byte = 8'h00;

  always #5 clk = ~clk;

  cam_capture_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overflow(overflow), .byte_count(byte_count)
  );

  cam_capture_ctrl #(.ADDR_W(ADDR_W), .MAX_BYTES(SMALL_MAX)) dut_small (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk), .cam_data(cam_data),
    .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data), .busy(o_busy), .done(o_done),
    .overflow(o_overflow), .byte_count(o_byte_count)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1)   wr_cnt     <= wr_cnt + 1;
    if (o_wr_en === 1'b1) o_wr_cnt   <= o_wr_cnt + 1;
    if (done === 1'b1)    done_cnt   <= done_cnt + 1;
    if (o_done === 1'b1)  o_done_cnt <= o_done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic snap();
    w0 = wr_cnt; ow0 = o_wr_cnt; d0 = done_cnt; od0 = o_done_cnt;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  // One camera byte: pclk low 4 clk, high 4 clk; the write is expected on the
  // third falling clk edge after pclk is raised (2 sync stages + write register).
  task automatic cam_byte(input logic [7:0] d);
    cam_data = d;
    @(negedge clk); cam_pclk = 1'b1;
    repeat (3) @(negedge clk);
    if (exp_cap) begin
`ifdef CAM_BYTE_PACK_EN
      if (exp_idx % 2 == 1) begin
        check_eq("wr_en", wr_en, 1);
        check_eq("wr_addr", wr_addr, exp_idx / 2);
        check_eq("wr_data", wr_data, {prev_byte, d});
        check_eq("small_wr_en", o_wr_en, (exp_idx / 2 < SMALL_MAX / 2));
      end else begin
        check_eq("wr_en_first_of_pair", wr_en, 0);
        check_eq("small_wr_en_first_of_pair", o_wr_en, 0);
        prev_byte = d;
      end
`else
      check_eq("wr_en", wr_en, 1);
      check_eq("wr_addr", wr_addr, exp_idx);
      check_eq("wr_data", wr_data, {8'h00, d});
      check_eq("small_wr_en", o_wr_en, (exp_idx < SMALL_MAX));
      if (exp_idx < SMALL_MAX) check_eq("small_wr_addr", o_wr_addr, exp_idx);
`endif
      exp_idx++;
    end else begin
      check_eq("wr_en_not_capturing", wr_en, 0);
      check_eq("small_wr_en_not_capturing", o_wr_en, 0);
    end
    @(negedge clk); cam_pclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // A frame of 4 lines; optionally a start after a given line or an abort
  // before a given byte index.
  task automatic cam_frame(input int nb, input logic [7:0] base, input bit cap,
                           input int start_line, input int abort_at);
    int n;
    n = 0;
    repeat (6) @(negedge clk);
    cam_vsync = 1'b0;
    exp_cap = cap;
    exp_idx = 0;
    repeat (8) @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      cam_href = 1'b1;
      for (int b = 0; b < nb; b++) begin
        if (n == abort_at) begin
          pulse_abort();
          check_eq("busy_after_abort", busy, 0);
          check_eq("small_busy_after_abort", o_busy, 0);
          exp_cap = 1'b0;
        end
        cam_byte(base + 8'(n));
        n++;
      end
      cam_href = 1'b0;
      repeat (6) @(negedge clk);
      if (l == start_line) pulse_start();
    end
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    exp_cap = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_pclk = 1'b0; cam_data = 8'h00;

    // Reset held 3 clk while the camera lines toggle.
    repeat (3) begin
      @(negedge clk);
      cam_pclk = ~cam_pclk; cam_href = ~cam_href; cam_vsync = ~cam_vsync;
      cam_data = cam_data + 8'h35;
    end
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_byte_count", byte_count, 0);
    rst = 1'b0;
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; cam_data = 8'h00;
    repeat (6) @(negedge clk);
    check_eq("post_rst_no_writes", wr_cnt, 0);
    check_eq("post_rst_busy", busy, 0);

    // Full frame of 32 bytes; the small instance overflows after 20.
    snap();
    pulse_start();
    check_eq("busy_after_start", busy, 1);
    cam_frame(8, 8'h00, 1'b1, -1, -1);
    check_eq("frame1_writes", wr_cnt - w0, FULL_W);
    check_eq("frame1_done", done_cnt - d0, 1);
    check_eq("frame1_byte_count", byte_count, 32);
    check_eq("frame1_overflow", overflow, 0);
    check_eq("frame1_busy", busy, 0);
    check_eq("small_writes", o_wr_cnt - ow0, SMALL_W);
    check_eq("small_done", o_done_cnt - od0, 1);
    check_eq("small_byte_count", o_byte_count, 32);
    check_eq("small_overflow", o_overflow, 1);

    // Start issued mid-frame: nothing until the next VSYNC fall.
    snap();
    cam_frame(8, 8'h40, 1'b0, 1, -1);
    check_eq("midstart_writes", wr_cnt - w0, 0);
    check_eq("midstart_done", done_cnt - d0, 0);
    check_eq("midstart_armed_busy", busy, 1);
    snap();
    cam_frame(8, 8'h80, 1'b1, -1, -1);
    check_eq("next_frame_writes", wr_cnt - w0, FULL_W);
    check_eq("next_frame_done", done_cnt - d0, 1);
    check_eq("next_frame_byte_count", byte_count, 32);

    // Second start during capture must be ignored.
    snap();
    pulse_start();
    cam_frame(8, 8'h20, 1'b1, 1, -1);
    check_eq("restart_ignored_writes", wr_cnt - w0, FULL_W);
    check_eq("restart_ignored_byte_count", byte_count, 32);
    check_eq("restart_ignored_done", done_cnt - d0, 1);

    // Abort after 10 bytes.
    snap();
    pulse_start();
    cam_frame(8, 8'h60, 1'b1, -1, 10);
    check_eq("abort_writes", wr_cnt - w0, ABORT_W);
    check_eq("abort_done", done_cnt - d0, 0);
    check_eq("abort_byte_count", byte_count, 10);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_overflow", overflow, 0);
    check_eq("small_abort_byte_count", o_byte_count, 10);
    check_eq("small_abort_overflow", o_overflow, 0);

    // Start and abort together: abort wins.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    check_eq("start_abort_busy_later", busy, 0);
    snap();
    cam_frame(8, 8'h10, 1'b0, -1, -1);
    check_eq("start_abort_no_writes", wr_cnt - w0, 0);
    check_eq("start_abort_no_done", done_cnt - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
